// File: rtl/writeback_queue_if.sv
// rtl/writeback_queue_if.sv - producer-side write offer handshake for writeback_queue
// Ports (signals):
//   in_valid  producer offers a register write
//   in_ready  queue can accept an entry this cycle
//   in_reg    destination register index of the offered write
//   in_data   data of the offered write
// Modports: master = producer (ALU/memory stage), slave = writeback_queue.
interface writeback_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;

    modport master (output in_valid, output in_reg, output in_data, input in_ready);
    modport slave  (input in_valid, input in_reg, input in_data, output in_ready);
endinterface

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - pending register-write queue feeding the RegisterFile write port
// Optional feature macro: WB_BYPASS_EN (compiles in read-forwarding of pending values).
// Ports:
//   clk                   single clock, all state on rising edge
//   reset                 asynchronous active-low reset
//   prod                  writeback_queue_if.slave, producer write offer handshake
//   wbStall               blocks draining for the current cycle
//   regWrite/writeReg/writeData  registered RegisterFile write port
//   RD1, RD2              read indices presented to the RegisterFile
//   fwdHit1/2, fwdData1/2 newer pending value for RD1/RD2 (0 when bypass not built)
//   count                 entries queued, excluding the output stage
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    writeback_queue_if.slave         prod,
    input  logic                     wbStall,
    output logic                     regWrite,
    output logic [4:0]               writeReg,
    output logic [31:0]              writeData,
    input  logic [4:0]               RD1,
    input  logic [4:0]               RD2,
    output logic                     fwdHit1,
    output logic                     fwdHit2,
    output logic [31:0]              fwdData1,
    output logic [31:0]              fwdData2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [4:0]    ent_reg_q  [DEPTH];
    logic [4:0]    ent_reg_d  [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [31:0]   ent_data_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          reg_write_q, reg_write_d;
    logic [4:0]    write_reg_q, write_reg_d;
    logic [31:0]   write_data_q, write_data_d;

    logic accept;
    logic push;
    logic pop;

    // Full is judged on the current count only, so a drain on the same edge
    // never lets a new entry slip in.
    assign prod.in_ready = (count_q < DEPTH_C);

    always_comb begin
        ent_reg_d    = ent_reg_q;
        ent_data_d   = ent_data_q;
        head_d       = head_q;
        tail_d       = tail_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;

        accept = prod.in_valid && prod.in_ready;
        // Writes to register 0 are accepted but dropped: it is hard-wired zero.
        push   = accept && (prod.in_reg != 5'd0);
        // Pop looks at the pre-edge count, so an entry accepted into an
        // empty queue waits one edge before draining.
        pop    = (count_q != '0) && !wbStall;

        if (push) begin
            ent_reg_d[tail_q]  = prod.in_reg;
            ent_data_d[tail_q] = prod.in_data;
            tail_d             = tail_q + AW'(1);
        end
        if (pop) begin
            reg_write_d  = 1'b1;
            write_reg_d  = ent_reg_q[head_q];
            write_data_d = ent_data_q[head_q];
            head_d       = head_q + AW'(1);
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            ent_reg_q    <= ent_reg_d;
            ent_data_q   <= ent_data_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign regWrite  = reg_write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign count     = count_q;

`ifdef WB_BYPASS_EN
    // Returns {hit, data}. The output stage is older than anything still
    // queued, and the queue is scanned oldest to youngest, so the last
    // match found is the youngest value.
    function automatic logic [32:0] lookup(input logic [4:0] rd);
        logic [32:0]   r;
        logic [AW-1:0] idx;
        r = '0;
        if (rd != 5'd0) begin
            if (reg_write_q && (write_reg_q == rd)) r = {1'b1, write_data_q};
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_q + AW'(i);
                if ((i < int'(count_q)) && (ent_reg_q[idx] == rd)) r = {1'b1, ent_data_q[idx]};
            end
        end
        return r;
    endfunction

    always_comb begin
        {fwdHit1, fwdData1} = lookup(RD1);
        {fwdHit2, fwdData2} = lookup(RD2);
    end
`else
    logic unused_rd;
    assign unused_rd = ^{RD1, RD2};
    assign fwdHit1   = 1'b0;
    assign fwdHit2   = 1'b0;
    assign fwdData1  = '0;
    assign fwdData2  = '0;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - self-checking bench for writeback_queue
module tb_writeback_queue;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        wbStall;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  RD1, RD2;
    logic        fwdHit1, fwdHit2;
    logic [31:0] fwdData1, fwdData2;
    logic [2:0]  count;

    writeback_queue_if wb_if ();

    writeback_queue #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .prod(wb_if), .wbStall(wbStall),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .RD1(RD1), .RD2(RD2), .fwdHit1(fwdHit1), .fwdHit2(fwdHit2),
        .fwdData1(fwdData1), .fwdData2(fwdData2), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  r;
        logic [31:0] d;
        logic        st;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic        e_rw;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
    } vec_t;

    vec_t vecs[$];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [4:0] r, input logic [31:0] d, input logic st,
                       input logic [4:0] rd1, input logic [4:0] rd2,
                       input logic e_rw, input logic [4:0] e_wr, input logic [31:0] e_wd,
                       input logic [2:0] e_cnt, input logic e_rdy,
                       input logic e_h1, input logic [31:0] e_d1,
                       input logic e_h2, input logic [31:0] e_d2);
        vec_t t;
        t.v = v; t.r = r; t.d = d; t.st = st; t.rd1 = rd1; t.rd2 = rd2;
        t.e_rw = e_rw; t.e_wr = e_wr; t.e_wd = e_wd; t.e_cnt = e_cnt; t.e_rdy = e_rdy;
        t.e_h1 = e_h1 & BYP; t.e_d1 = BYP ? e_d1 : 32'h0;
        t.e_h2 = e_h2 & BYP; t.e_d2 = BYP ? e_d2 : 32'h0;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d, input logic st);
        wb_if.in_valid = v;
        wb_if.in_reg   = r;
        wb_if.in_data  = d;
        wbStall        = st;
    endtask

    initial begin
        int pushed;
        int written;
        bit saw_rdy0;
        logic [127:0] act, exp;

        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        RD1 = 5'd0;
        RD2 = 5'd0;

        //  v  r   d             st rd1 rd2  rw wr  wd            cnt rdy h1 d1      h2 d2
        add(1, 1, 32'hDEADBEEF, 0, 0, 0,   0, 0, 32'h0,        0, 1,  0, 32'h0,  0, 32'h0);
        add(0, 0, 32'h0,        0, 0, 0,   0, 0, 32'h0,        1, 1,  0, 32'h0,  0, 32'h0);
        add(0, 0, 32'h0,        0, 0, 0,   1, 1, 32'hDEADBEEF, 0, 1,  0, 32'h0,  0, 32'h0);
        add(0, 0, 32'h0,        0, 0, 0,   0, 1, 32'hDEADBEEF, 0, 1,  0, 32'h0,  0, 32'h0);
        add(1, 0, 32'hFFFFFFFF, 0, 0, 0,   0, 1, 32'hDEADBEEF, 0, 1,  0, 32'h0,  0, 32'h0);
        add(0, 0, 32'h0,        0, 0, 0,   0, 1, 32'hDEADBEEF, 0, 1,  0, 32'h0,  0, 32'h0);
        add(0, 0, 32'h0,        0, 0, 0,   0, 1, 32'hDEADBEEF, 0, 1,  0, 32'h0,  0, 32'h0);
        add(1, 1, 32'h11,       1, 1, 0,   0, 1, 32'hDEADBEEF, 0, 1,  0, 32'h0,  0, 32'h0);
        add(1, 2, 32'h22,       1, 1, 0,   0, 1, 32'hDEADBEEF, 1, 1,  1, 32'h11, 0, 32'h0);
        add(1, 3, 32'h33,       1, 2, 1,   0, 1, 32'hDEADBEEF, 2, 1,  1, 32'h22, 1, 32'h11);
        add(1, 4, 32'h44,       1, 0, 0,   0, 1, 32'hDEADBEEF, 3, 1,  0, 32'h0,  0, 32'h0);
        add(1, 9, 32'h99,       1, 4, 0,   0, 1, 32'hDEADBEEF, 4, 0,  1, 32'h44, 0, 32'h0);
        add(0, 0, 32'h0,        1, 0, 0,   0, 1, 32'hDEADBEEF, 4, 0,  0, 32'h0,  0, 32'h0);
        add(0, 0, 32'h0,        0, 0, 0,   0, 1, 32'hDEADBEEF, 4, 0,  0, 32'h0,  0, 32'h0);
        add(0, 0, 32'h0,        0, 1, 0,   1, 1, 32'h11,       3, 1,  1, 32'h11, 0, 32'h0);
        add(0, 0, 32'h0,        0, 0, 0,   1, 2, 32'h22,       2, 1,  0, 32'h0,  0, 32'h0);
        add(0, 0, 32'h0,        0, 0, 0,   1, 3, 32'h33,       1, 1,  0, 32'h0,  0, 32'h0);
        add(0, 0, 32'h0,        0, 0, 0,   1, 4, 32'h44,       0, 1,  0, 32'h0,  0, 32'h0);
        add(0, 0, 32'h0,        0, 0, 0,   0, 4, 32'h44,       0, 1,  0, 32'h0,  0, 32'h0);
        add(1, 7, 32'hA,        1, 0, 0,   0, 4, 32'h44,       0, 1,  0, 32'h0,  0, 32'h0);
        add(1, 7, 32'hB,        1, 7, 0,   0, 4, 32'h44,       1, 1,  1, 32'hA,  0, 32'h0);
        add(0, 0, 32'h0,        1, 7, 0,   0, 4, 32'h44,       2, 1,  1, 32'hB,  0, 32'h0);
        add(0, 0, 32'h0,        0, 7, 0,   0, 4, 32'h44,       2, 1,  1, 32'hB,  0, 32'h0);
        add(0, 0, 32'h0,        0, 7, 0,   1, 7, 32'hA,        1, 1,  1, 32'hB,  0, 32'h0);
        add(0, 0, 32'h0,        0, 7, 0,   1, 7, 32'hB,        0, 1,  1, 32'hB,  0, 32'h0);
        add(0, 0, 32'h0,        0, 7, 0,   0, 7, 32'hB,        0, 1,  0, 32'h0,  0, 32'h0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", {count, regWrite, writeReg, writeData, fwdHit1, fwdHit2, fwdData1, fwdData2},
            {3'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0});
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ready_after_release", {127'h0, wb_if.in_ready}, {127'h0, 1'b1});

        // Table-driven vectors: inputs held through the cycle, outputs sampled mid-cycle
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].st);
            RD1 = vecs[i].rd1;
            RD2 = vecs[i].rd2;
            #1;
            act = {regWrite, writeReg, writeData, count, wb_if.in_ready, fwdHit1, fwdData1, fwdHit2, fwdData2};
            exp = {vecs[i].e_rw, vecs[i].e_wr, vecs[i].e_wd, vecs[i].e_cnt, vecs[i].e_rdy,
                   vecs[i].e_h1, vecs[i].e_d1, vecs[i].e_h2, vecs[i].e_d2};
            chk($sformatf("row%0d", i), act, exp);
        end
        RD1 = 5'd0;

        // Streaming through a full queue: reg 5, data 0..7 in order
        pushed   = 0;
        written  = 0;
        saw_rdy0 = 1'b0;
        for (int c = 0; c < 60 && written < 8; c++) begin
            @(negedge clk);
            drive(pushed < 8, 5'd5, 32'(pushed), pushed < 4);
            #1;
            chk("stream_count_max", {127'h0, count <= 3'd4}, {127'h0, 1'b1});
            if (regWrite) begin
                chk($sformatf("stream_write%0d", written), {91'h0, writeReg, writeData},
                    {91'h0, 5'd5, 32'(written)});
                written++;
            end
            if (!wbStall && !wb_if.in_ready) saw_rdy0 = 1'b1;
            if (wb_if.in_valid && wb_if.in_ready) pushed++;
        end
        chk("stream_total_writes", 128'(written), 128'd8);
        chk("stream_ready_dropped_when_full", {127'h0, saw_rdy0}, {127'h0, 1'b1});

        // Reset mid-operation discards queued entries
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h1, 1'b1);
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h2, 1'b1);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1);
        #1;
        chk("midreset_pre_count", 128'(count), 128'd2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_during", {125'h0, count, regWrite, wb_if.in_ready} >> 0,
            {125'h0, 3'd0, 1'b0, 1'b1});
        @(negedge clk);
        reset   = 1'b1;
        wbStall = 1'b0;
        #1;
        chk("midreset_ready_after_release", {127'h0, wb_if.in_ready}, {127'h0, 1'b1});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("midreset_no_write%0d", c), {124'h0, regWrite, count}, {124'h0, 1'b0, 3'd0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
